vga_image_scanner: RTL and testbench

VGA_IMAGE_SCANNER -- requirements
Module: vga_image_scanner

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_timing_gen.sv | 56 +++++
 rtl/vga_image_scanner.sv | 160 ++++++++++++++++
 tb/tb_vga_image_scanner.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, widths and pixel payload type.
package vga_pkg;

  // Horizontal timing in pixel ticks
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned H_TOTAL = 800;

  // Vertical timing in lines
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;
  localparam int unsigned V_TOTAL = 525;

  // Sync pulses sit just before the back porch at the end of each period
  localparam int unsigned H_SYNC_START = H_TOTAL - H_BP - H_SYNC;
  localparam int unsigned V_SYNC_START = V_TOTAL - V_BP - V_SYNC;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ADDR_W = 19;

  // Test-pattern bar geometry: 8 bars of 80 pixels
  localparam int unsigned BAR_W     = 80;
  localparam int unsigned BAR_CNT_W = 7;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Bar index bits select full-on or off per channel
  function automatic rgb_t bar_rgb(input logic [2:0] idx);
    rgb_t c;
    c.r = {4{idx[2]}};
    c.g = {4{idx[1]}};
    c.b = {4{idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider plus horizontal/vertical counters and raw sync decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned V_VIS   = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_ce,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             visible_c,
  output logic             hsync_c,
  output logic             vsync_c
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;

  // Divider wraps CLK_DIV-1 -> 0; pix_ce is registered so it is high while div_cnt == CLK_DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
      pix_ce  <= (div_cnt == DIV_W'(CLK_DIV - 2));
    end
  end

  // Raster position, advanced once per pixel tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Active-high decode of the current raster position
  always_comb begin
    visible_c = (h_cnt < CNT_W'(H_VIS)) && (v_cnt < CNT_W'(V_VIS));
    hsync_c   = (h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt < CNT_W'(H_SYNC_START + H_SYNC));
    vsync_c   = (v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt < CNT_W'(V_SYNC_START + V_SYNC));
  end

endmodule

// File: rtl/vga_image_scanner.sv
// VGA scanner: reads a grayscale frame buffer in raster order and drives RGB/sync.
// Optional colour-bar test pattern with test_mode input when VGA_TEST_PATTERN_EN is defined.
module vga_image_scanner
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned V_VIS   = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] vgaAddress,
  input  logic [7:0]        ImageData,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  logic             pix_ce;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             visible_c;
  logic             hsync_c;
  logic             vsync_c;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .V_VIS   (V_VIS)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_ce    (pix_ce),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .visible_c (visible_c),
    .hsync_c   (hsync_c),
    .vsync_c   (vsync_c)
  );

  logic line_last_c;
  logic frame_last_c;
  logic next_vis_c;
  logic unused_c;

  assign unused_c = ^ImageData[3:0];

  // Look ahead to the pixel the counters move to on the next tick
  always_comb begin
    line_last_c  = (h_cnt == CNT_W'(H_TOTAL - 1));
    frame_last_c = line_last_c && (v_cnt == CNT_W'(V_TOTAL - 1));
    next_vis_c   = 1'b0;
    if (line_last_c) begin
      next_vis_c = frame_last_c || ((v_cnt + CNT_W'(1)) < CNT_W'(V_VIS));
    end else begin
      next_vis_c = ((h_cnt + CNT_W'(1)) < CNT_W'(H_VIS)) && (v_cnt < CNT_W'(V_VIS));
    end
  end

  // Address tracks the raster: +1 on entering a visible pixel, held in blanking, 0 at frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vgaAddress <= '0;
    end else if (pix_ce) begin
      if (frame_last_c) begin
        vgaAddress <= '0;
      end else if (next_vis_c) begin
        vgaAddress <= vgaAddress + ADDR_W'(1);
      end
    end
  end

  rgb_t pix_rgb_c;

`ifdef VGA_TEST_PATTERN_EN
  logic [BAR_CNT_W-1:0] bar_px;
  logic [2:0]           bar_idx;

  // Bar position within the line: index = h_cnt / 80 without a divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (pix_ce) begin
      if (line_last_c) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_px == BAR_CNT_W'(BAR_W - 1)) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'(1);
      end else begin
        bar_px  <= bar_px + BAR_CNT_W'(1);
      end
    end
  end
`endif

  // Pixel colour source: grey replicated, or colour bars in test mode
  always_comb begin
    pix_rgb_c.r = ImageData[7:4];
    pix_rgb_c.g = ImageData[7:4];
    pix_rgb_c.b = ImageData[7:4];
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) begin
      pix_rgb_c = bar_rgb(bar_idx);
    end
`endif
  end

  rgb_t s1_rgb;
  logic s1_vis;
  logic s1_hs;
  logic s1_vs;
  logic s1_first;

  // Stage 1: capture memory data (one tick after its address) with the matching raster flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rgb   <= '0;
      s1_vis   <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_first <= 1'b0;
    end else if (pix_ce) begin
      s1_rgb   <= pix_rgb_c;
      s1_vis   <= visible_c;
      s1_hs    <= hsync_c;
      s1_vs    <= vsync_c;
      s1_first <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Stage 2: registered pins, blanked outside the visible area, syncs active-low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red         <= 4'h0;
      green       <= 4'h0;
      blue        <= 4'h0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce && s1_first;
      if (pix_ce) begin
        red   <= s1_vis ? s1_rgb.r : 4'h0;
        green <= s1_vis ? s1_rgb.g : 4'h0;
        blue  <= s1_vis ? s1_rgb.b : 4'h0;
        hsync <= ~s1_hs;
        vsync <= ~s1_vs;
      end
    end
  end

endmodule

// File: tb/tb_vga_image_scanner.sv
// Scoreboard bench for vga_image_scanner; pixel-tick walker with closed-form raster model.
module tb_vga_image_scanner;

  // Smallest legal divider keeps the multi-frame run short
  localparam int unsigned DIV       = 2;
  localparam int unsigned HV        = 640;
  localparam int unsigned VV        = 480;
  localparam int unsigned HT        = 800;
  localparam int unsigned VT        = 525;
  localparam int unsigned FRAME     = HT * VT;
  localparam int unsigned LAST_ADDR = HV * VV - 1;
  localparam int unsigned LAST_PIX  = 479 * HT + 639;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
    logic       fs;
  } pins_t;

  localparam pins_t RST_PINS = '{r: 4'h0, g: 4'h0, b: 4'h0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [18:0] vga_address;
  logic [7:0]  image_data = 8'h00;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic        test_mode = 1'b0;

  pins_t       sb[$];
  pins_t       cur;
  int unsigned p = 0;
  int unsigned cyc = 0;
  int unsigned fs_count = 0;
  int          compared = 0;
  int          mismatched = 0;

  vga_image_scanner #(
    .CLK_DIV (DIV),
    .H_VIS   (HV),
    .V_VIS   (VV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vgaAddress  (vga_address),
    .ImageData   (image_data),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Memory model: returns addr[7:0] one clk after the address
  always @(posedge clk) image_data <= vga_address[7:0];

  // Clock edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Counts clk cycles in which frame_start is high
  always @(negedge clk) begin
    if (frame_start === 1'b1) fs_count <= fs_count + 1;
  end

  function automatic logic [18:0] exp_addr(input int unsigned q);
    int unsigned h;
    int unsigned v;
    h = q % HT;
    v = (q / HT) % VT;
    if (v >= VV) return 19'(LAST_ADDR);
    if (h >= HV) return 19'(v * HV + HV - 1);
    return 19'(v * HV + h);
  endfunction

  function automatic pins_t exp_pix(input int unsigned q);
    int unsigned h;
    int unsigned v;
    logic [18:0] a;
    logic [2:0]  idx;
    pins_t       e;
    h = q % HT;
    v = (q / HT) % VT;
    e.hs = !(h >= 656 && h < 752);
    e.vs = !(v >= 490 && v < 492);
    e.fs = (h == 0) && (v == 0);
    e.r = 4'h0;
    e.g = 4'h0;
    e.b = 4'h0;
    if (h < HV && v < VV) begin
      if (test_mode) begin
        idx = 3'(h / 80);
        e.r = {4{idx[2]}};
        e.g = {4{idx[1]}};
        e.b = {4{idx[0]}};
      end else begin
        a = exp_addr(q);
        e.r = a[7:4];
        e.g = a[7:4];
        e.b = a[7:4];
      end
    end
    return e;
  endfunction

  function automatic pins_t observed();
    return {red, green, blue, hsync, vsync, frame_start};
  endfunction

  // Queue the current pixel's pin values (they appear 2 ticks later), then step one tick
  task automatic advance();
    sb.push_back(exp_pix(p));
    repeat (DIV) @(posedge clk);
    #1;
    p++;
    cur = sb.pop_front();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    p = 0;
    sb.delete();
    sb.push_back(RST_PINS);
    cur = RST_PINS;
  endtask

  task automatic test_reset();
    pins_t obs;
    #2 rst_n = 1'b0;
    #1;
    obs = observed();
    if (obs !== RST_PINS) begin
      mismatched++;
      $display("FAIL reset_async_pins got %h want %h", obs, RST_PINS);
    end
    compared++;
    if (vga_address !== 19'd0) begin
      mismatched++;
      $display("FAIL reset_async_addr got %0d want 0", vga_address);
    end
    compared++;
    repeat (3) @(posedge clk);
    #1;
    obs = observed();
    if (obs !== RST_PINS) begin
      mismatched++;
      $display("FAIL reset_held_pins got %h want %h", obs, RST_PINS);
    end
    compared++;
    release_reset();
    #1;
    if (vga_address !== 19'd0) begin
      mismatched++;
      $display("FAIL reset_release_addr got %0d want 0", vga_address);
    end
    compared++;
  endtask

  task automatic test_line0();
    pins_t       obs;
    logic        prev_hs;
    int unsigned fall0;
    int unsigned fall1;
    int unsigned nfall;
    prev_hs = 1'b1;
    fall0 = 0;
    fall1 = 0;
    nfall = 0;
    for (int i = 0; i < int'(2 * HT + 10); i++) begin
      advance();
      if (vga_address !== exp_addr(p)) begin
        mismatched++;
        $display("FAIL line0_addr p=%0d got %0d want %0d", p, vga_address, exp_addr(p));
      end
      compared++;
      obs = observed();
      if (obs !== cur) begin
        mismatched++;
        $display("FAIL line0_pins p=%0d got %h want %h", p, obs, cur);
      end
      compared++;
      if (prev_hs && !hsync) begin
        if (nfall == 0) fall0 = cyc;
        else if (nfall == 1) fall1 = cyc;
        nfall++;
      end
      prev_hs = hsync;
    end
    if (fall0 != (656 + 2) * DIV) begin
      mismatched++;
      $display("FAIL hsync_first_fall got %0d clk want %0d clk", fall0, (656 + 2) * DIV);
    end
    compared++;
    if (fall1 - fall0 != HT * DIV) begin
      mismatched++;
      $display("FAIL hsync_period got %0d clk want %0d clk", fall1 - fall0, HT * DIV);
    end
    compared++;
  endtask

  task automatic test_mid_frame_reset();
    pins_t obs;
    while (p < 200 * HT + 300) advance();
    obs = observed();
    if (obs !== cur) begin
      mismatched++;
      $display("FAIL pre_reset_pins got %h want %h", obs, cur);
    end
    compared++;
    if (vga_address !== exp_addr(p)) begin
      mismatched++;
      $display("FAIL pre_reset_addr got %0d want %0d", vga_address, exp_addr(p));
    end
    compared++;
    rst_n = 1'b0;
    #1;
    obs = observed();
    if (obs !== RST_PINS) begin
      mismatched++;
      $display("FAIL midreset_pins got %h want %h", obs, RST_PINS);
    end
    compared++;
    if (vga_address !== 19'd0) begin
      mismatched++;
      $display("FAIL midreset_addr got %0d want 0", vga_address);
    end
    compared++;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic test_full_frame();
    pins_t       obs;
    logic        prev_hs;
    logic        prev_vs;
    logic        win;
    int unsigned max_addr;
    int unsigned nfall;
    int unsigned vs_fall;
    int unsigned vs_rise;
    int unsigned fs0;
    int unsigned fs1;
    int unsigned nfs;
    int unsigned fs_base;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    max_addr = 0;
    nfall = 0;
    vs_fall = 0;
    vs_rise = 0;
    fs0 = 0;
    fs1 = 0;
    nfs = 0;
    fs_base = fs_count;
    while (p < FRAME + 1000) begin
      advance();
      win = (p < 2 * HT) || (p >= 478 * HT && p < 481 * HT) || (p >= FRAME - HT);
      if (win) begin
        if (vga_address !== exp_addr(p)) begin
          mismatched++;
          $display("FAIL frame_addr p=%0d got %0d want %0d", p, vga_address, exp_addr(p));
        end
        compared++;
        obs = observed();
        if (obs !== cur) begin
          mismatched++;
          $display("FAIL frame_pins p=%0d got %h want %h", p, obs, cur);
        end
        compared++;
      end
      if (p == LAST_PIX) begin
        if (vga_address !== 19'(LAST_ADDR)) begin
          mismatched++;
          $display("FAIL last_visible_addr got %0d want %0d", vga_address, LAST_ADDR);
        end
        compared++;
      end
      if (32'(vga_address) > max_addr) max_addr = 32'(vga_address);
      if (prev_hs && !hsync && p <= FRAME) nfall++;
      if (prev_vs && !vsync && vs_fall == 0) vs_fall = cyc;
      if (!prev_vs && vsync && vs_fall != 0 && vs_rise == 0) vs_rise = cyc;
      if (frame_start) begin
        if (nfs == 0) fs0 = cyc;
        else if (nfs == 1) fs1 = cyc;
        nfs++;
      end
      prev_hs = hsync;
      prev_vs = vsync;
    end
    if (max_addr != LAST_ADDR) begin
      mismatched++;
      $display("FAIL max_addr got %0d want %0d", max_addr, LAST_ADDR);
    end
    compared++;
    if (nfall != VT) begin
      mismatched++;
      $display("FAIL hsync_pulses_per_frame got %0d want %0d", nfall, VT);
    end
    compared++;
    if (vs_rise - vs_fall != 2 * HT * DIV) begin
      mismatched++;
      $display("FAIL vsync_low_clk got %0d want %0d", vs_rise - vs_fall, 2 * HT * DIV);
    end
    compared++;
    if (fs0 != 2 * DIV) begin
      mismatched++;
      $display("FAIL first_frame_start got %0d clk want %0d clk", fs0, 2 * DIV);
    end
    compared++;
    if (fs1 - fs0 != FRAME * DIV) begin
      mismatched++;
      $display("FAIL frame_period got %0d clk want %0d clk", fs1 - fs0, FRAME * DIV);
    end
    compared++;
    if (fs_count - fs_base != 2) begin
      mismatched++;
      $display("FAIL frame_start_clks got %0d want 2", fs_count - fs_base);
    end
    compared++;
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    pins_t obs;
    test_mode = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < int'(HT + 10); i++) begin
      advance();
      if (vga_address !== exp_addr(p)) begin
        mismatched++;
        $display("FAIL pattern_addr p=%0d got %0d want %0d", p, vga_address, exp_addr(p));
      end
      compared++;
      obs = observed();
      if (obs !== cur) begin
        mismatched++;
        $display("FAIL pattern_pins p=%0d got %h want %h", p, obs, cur);
      end
      compared++;
      if (p == 42 && {red, green, blue} !== 12'h000) begin
        mismatched++;
        $display("FAIL pattern_bar0 got %h want 000", {red, green, blue});
      end
      if (p == 42) compared++;
      if (p == 602 && {red, green, blue} !== 12'hFFF) begin
        mismatched++;
        $display("FAIL pattern_bar7 got %h want fff", {red, green, blue});
      end
      if (p == 602) compared++;
    end
    test_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_line0();
    test_mid_frame_reset();
    test_full_frame();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
